// File: rtl/prog_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding and
// default ICCM geometry / end-of-program marker.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    DONE    = 3'd3,
    ERR     = 3'd4
  } state_t;

  localparam int unsigned DefAddrWidth = 12;
  localparam logic [31:0] DefEopWord   = 32'h0000_0FFF;

endpackage

// File: rtl/prog_loader.sv
// Assembles UART bytes into little-endian 32-bit words and streams them into
// ICCM, holding the core in reset until an end-of-program word arrives.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned AddrWidth     = DefAddrWidth,
  parameter logic [31:0] EopWord       = DefEopWord,
  parameter int unsigned TimeoutCycles = 1_000_000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 prog_i,
  input  logic                 rx_dv_i,
  input  logic [7:0]           rx_byte_i,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [31:0]          wdata_o,
  output logic                 prog_rst_no,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int unsigned TimerWidth = $clog2(TimeoutCycles + 1);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TimeoutCycles - 1);
  localparam logic [AddrWidth:0] MaxWords = {1'b1, {AddrWidth{1'b0}}};

  state_t                 r_state;
  logic [1:0]             r_byteIdx;
  logic [31:0]            r_word;
  logic [AddrWidth:0]     r_count;
  logic [TimerWidth-1:0]  r_timer;
  logic [AddrWidth-1:0]   r_addr;
  logic [31:0]            r_wdata;
  logic [31:0]            w_shiftWord;

  // Shifting in from the top leaves the first byte of a word in [7:0] after four bytes.
  assign w_shiftWord = {rx_byte_i, r_word[31:8]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_byteIdx <= '0;
      r_word    <= '0;
      r_count   <= '0;
      r_timer   <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (prog_i) begin
            r_state   <= COLLECT;
            r_byteIdx <= '0;
            r_count   <= '0;
            r_timer   <= '0;
          end
        end
        COLLECT: begin
          if (!prog_i) begin
            r_state   <= IDLE;
            r_byteIdx <= '0;
            r_timer   <= '0;
          end else if (rx_dv_i) begin
            r_word  <= w_shiftWord;
            r_timer <= '0;
            if (r_byteIdx == 2'd3) begin
              r_byteIdx <= '0;
              if (w_shiftWord == EopWord) begin
                r_state <= DONE;
              end else if (r_count == MaxWords) begin
                r_state <= ERR;
              end else begin
                r_state <= WRITE;
                r_addr  <= r_count[AddrWidth-1:0];
                r_wdata <= w_shiftWord;
              end
            end else begin
              r_byteIdx <= r_byteIdx + 2'd1;
            end
          end else if (r_byteIdx != 2'd0) begin
            // A stalled partial word is dropped once the line stays quiet too long.
            if (r_timer == TimerLast) begin
              r_state   <= ERR;
              r_byteIdx <= '0;
              r_timer   <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        WRITE: begin
          r_count <= r_count + 1'b1;
          if (!prog_i) begin
            r_state <= IDLE;
          end else begin
            r_state <= COLLECT;
            if (rx_dv_i) begin
              r_word    <= w_shiftWord;
              r_byteIdx <= 2'd1;
              r_timer   <= '0;
            end
          end
        end
        DONE, ERR: begin
          if (!prog_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign we_o        = (r_state == WRITE);
  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;
  assign prog_rst_no = (r_state == IDLE) || (r_state == DONE);
  assign done_o      = (r_state == DONE);
  assign err_o       = (r_state == ERR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a 4-word ICCM with a 16-cycle byte timeout,
// exercising load, end marker, timeout, overflow, abort and mid-load reset.
module tb_prog_loader;

  localparam int unsigned AddrWidth = 2;

  logic                 clk;
  logic                 rst;
  logic                 prog;
  logic                 rxDv;
  logic [7:0]           rxByte;
  logic                 weO;
  logic [AddrWidth-1:0] addrO;
  logic [31:0]          wdataO;
  logic                 progRstN;
  logic                 doneO;
  logic                 errO;

  int checkCount = 0;
  int passCount  = 0;
  logic [AddrWidth-1:0] wrAddrQ[$];
  logic [31:0]          wrDataQ[$];

  prog_loader #(
    .AddrWidth(AddrWidth),
    .EopWord(32'h0000_0FFF),
    .TimeoutCycles(16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .prog_i(prog),
    .rx_dv_i(rxDv),
    .rx_byte_i(rxByte),
    .we_o(weO),
    .addr_o(addrO),
    .wdata_o(wdataO),
    .prog_rst_no(progRstN),
    .done_o(doneO),
    .err_o(errO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logs every ICCM write so scenarios can check count, order and content.
  always @(negedge clk) begin
    if (weO) begin
      wrAddrQ.push_back(addrO);
      wrDataQ.push_back(wdataO);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one byte strobe; returns one time unit after the capturing edge.
  task automatic applyStimulus(input logic [7:0] b);
    rxDv   = 1'b1;
    rxByte = b;
    step();
    rxDv   = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] tmp;
      tmp = w >> (8 * i);
      applyStimulus(tmp[7:0]);
    end
  endtask

  task automatic startLoad();
    prog = 1'b1;
    step();
    wrAddrQ.delete();
    wrDataQ.delete();
  endtask

  task automatic endLoad();
    prog = 1'b0;
    step(2);
  endtask

  initial begin
    rst    = 1'b1;
    prog   = 1'b0;
    rxDv   = 1'b0;
    rxByte = 8'h00;
    step(2);
    checkOutput("rst_we", 32'(weO), 32'd0);
    checkOutput("rst_addr", 32'(addrO), 32'd0);
    checkOutput("rst_wdata", wdataO, 32'd0);
    checkOutput("rst_progrstn", 32'(progRstN), 32'd1);
    checkOutput("rst_done", 32'(doneO), 32'd0);
    checkOutput("rst_err", 32'(errO), 32'd0);
    rst = 1'b0;
    step();

    // Scenario 1: single word, then end marker
    startLoad();
    checkOutput("s1_collect_progrstn", 32'(progRstN), 32'd0);
    sendWord(32'h1234_5678);
    checkOutput("s1_we", 32'(weO), 32'd1);
    checkOutput("s1_addr", 32'(addrO), 32'd0);
    checkOutput("s1_wdata", wdataO, 32'h1234_5678);
    step();
    checkOutput("s1_we_low", 32'(weO), 32'd0);
    checkOutput("s1_wdata_hold", wdataO, 32'h1234_5678);
    sendWord(32'h0000_0FFF);
    checkOutput("s1_done", 32'(doneO), 32'd1);
    applyStimulus(8'hAA);
    step();
    checkOutput("s1_done_stays", 32'(doneO), 32'd1);
    checkOutput("s1_writes", wrAddrQ.size(), 32'd1);
    endLoad();
    checkOutput("s1_done_clear", 32'(doneO), 32'd0);
    checkOutput("s1_idle_progrstn", 32'(progRstN), 32'd1);

    // Scenario 2: three words back to back then end marker
    startLoad();
    sendWord(32'h1122_3344);
    sendWord(32'hA3A2_A1A0);
    sendWord(32'hDEAD_BEEF);
    sendWord(32'h0000_0FFF);
    step();
    checkOutput("s2_writes", wrAddrQ.size(), 32'd3);
    if (wrAddrQ.size() == 3) begin
      checkOutput("s2_addr0", 32'(wrAddrQ[0]), 32'd0);
      checkOutput("s2_addr1", 32'(wrAddrQ[1]), 32'd1);
      checkOutput("s2_addr2", 32'(wrAddrQ[2]), 32'd2);
      checkOutput("s2_data0", wrDataQ[0], 32'h1122_3344);
      checkOutput("s2_data1", wrDataQ[1], 32'hA3A2_A1A0);
      checkOutput("s2_data2", wrDataQ[2], 32'hDEAD_BEEF);
    end
    checkOutput("s2_done", 32'(doneO), 32'd1);
    checkOutput("s2_progrstn", 32'(progRstN), 32'd1);
    endLoad();

    // Scenario 3: two bytes then silence until timeout
    startLoad();
    applyStimulus(8'h01);
    applyStimulus(8'h02);
    step(15);
    checkOutput("s3_err_early", 32'(errO), 32'd0);
    step();
    checkOutput("s3_err", 32'(errO), 32'd1);
    checkOutput("s3_err_progrstn", 32'(progRstN), 32'd0);
    checkOutput("s3_writes", wrAddrQ.size(), 32'd0);
    endLoad();
    checkOutput("s3_err_clear", 32'(errO), 32'd0);
    checkOutput("s3_progrstn_rel", 32'(progRstN), 32'd1);

    // Scenario 4: five words overflow a 4-word memory
    startLoad();
    for (int i = 0; i < 4; i++) begin
      sendWord(32'h1000_0000 + 32'(i));
      checkOutput("s4_err_low", 32'(errO), 32'd0);
    end
    sendWord(32'h5555_5555);
    checkOutput("s4_err", 32'(errO), 32'd1);
    checkOutput("s4_we_low", 32'(weO), 32'd0);
    step();
    checkOutput("s4_writes", wrAddrQ.size(), 32'd4);
    for (int i = 0; i < wrAddrQ.size() && i < 4; i++) begin
      checkOutput("s4_addr", 32'(wrAddrQ[i]), 32'(i));
      checkOutput("s4_data", wrDataQ[i], 32'h1000_0000 + 32'(i));
    end
    endLoad();

    // Scenario 5: abort after a partial word, then a clean word
    startLoad();
    applyStimulus(8'hEE);
    applyStimulus(8'hDD);
    prog = 1'b0;
    step(2);
    checkOutput("s5_abort_progrstn", 32'(progRstN), 32'd1);
    prog = 1'b1;
    step();
    sendWord(32'h0000_0001);
    checkOutput("s5_we", 32'(weO), 32'd1);
    checkOutput("s5_addr", 32'(addrO), 32'd0);
    checkOutput("s5_wdata", wdataO, 32'h0000_0001);
    step();
    checkOutput("s5_writes", wrAddrQ.size(), 32'd1);
    endLoad();

    // Scenario 6: reset pulsed mid-word
    startLoad();
    sendWord(32'h0BAD_F00D);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    rst = 1'b1;
    #2;
    checkOutput("s6_rst_we", 32'(weO), 32'd0);
    checkOutput("s6_rst_addr", 32'(addrO), 32'd0);
    checkOutput("s6_rst_wdata", wdataO, 32'd0);
    checkOutput("s6_rst_progrstn", 32'(progRstN), 32'd1);
    checkOutput("s6_rst_done", 32'(doneO), 32'd0);
    checkOutput("s6_rst_err", 32'(errO), 32'd0);
    step();
    rst = 1'b0;
    step(2);
    checkOutput("s6_post_rst_writes", wrAddrQ.size(), 32'd1);
    sendWord(32'hCAFE_F00D);
    checkOutput("s6_we", 32'(weO), 32'd1);
    checkOutput("s6_addr", 32'(addrO), 32'd0);
    checkOutput("s6_wdata", wdataO, 32'hCAFE_F00D);
    endLoad();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001: Parameter AddrWidth, default 12, meaning ICCM word-address width.
REQ-002: Parameter EopWord, default 32'h0000_0FFF, meaning end-of-program marker word, never written to ICCM.
REQ-003: Parameter TimeoutCycles, default 1_000_000, meaning maximum idle cycles between bytes inside a partially received word.
REQ-004: The block SHALL use one clock and an asynchronous, active-high reset; ports clk_i and rst_i are fixed as decided.
REQ-005: clk_i  input  1  system clock; all state changes on its rising edge.
REQ-006: rst_i  input  1  asynchronous active-high reset.
REQ-007: prog_i  input  1  level; high requests programming mode.
REQ-008: rx_dv_i  input  1  one-cycle strobe; rx_byte_i is valid this cycle.
REQ-009: rx_byte_i  input  8  received UART byte.
REQ-010: we_o  output  1  one-cycle ICCM write strobe.
REQ-011: addr_o  output  AddrWidth  ICCM word address for the write.
REQ-012: wdata_o  output  32  ICCM write data.
REQ-013: prog_rst_no  output  1  active-low core/system reset request.
REQ-014: done_o  output  1  program loaded successfully.
REQ-015: err_o  output  1  load aborted on overflow or timeout.

Function
REQ-016: The FSM SHALL have states IDLE, COLLECT, WRITE, DONE and ERR.
REQ-017: IDLE: prog_rst_no=1; prog_i high -> COLLECT next cycle; word address, byte index and word count cleared; prog_rst_no=0 from the COLLECT cycle onward.
REQ-018: Bytes SHALL be assembled little-endian: the first byte of a word goes to [7:0], the fourth to [31:24].
REQ-019: rx_dv_i SHALL be accepted in COLLECT and WRITE and ignored in IDLE, DONE and ERR.
REQ-020: On the 4th byte, if the assembled word equals EopWord -> DONE, with no write.
REQ-021: On the 4th byte, if word count equals 2^AddrWidth -> ERR, with no write (overflow).
REQ-022: On the 4th byte otherwise -> WRITE.
REQ-023: WRITE SHALL last exactly one cycle, with we_o=1 and addr_o/wdata_o holding the word; the address increments afterwards (count width AddrWidth+1); next state COLLECT.
REQ-024: Write latency SHALL be 1 cycle: we_o is asserted in the cycle after the 4th byte's rx_dv_i.
REQ-025: A byte arriving during WRITE SHALL be captured as byte 0 of the next word.
REQ-026: Timeout: in COLLECT with byte index != 0, a counter SHALL count cycles since the last byte; reaching TimeoutCycles -> ERR and the partial word is discarded.
REQ-027: The timeout counter SHALL reset on every accepted byte and be held at 0 when the byte index is 0.
REQ-028: prog_i low in COLLECT or WRITE SHALL abort to IDLE; the partial word is discarded, and a WRITE already in progress completes its single cycle.
REQ-029: DONE: done_o=1 and prog_rst_no=1; remain in DONE while prog_i is high; prog_i low -> IDLE and done_o=0.
REQ-030: ERR: err_o=1 and prog_rst_no=0; prog_i low -> IDLE, which clears err_o and releases prog_rst_no.
REQ-031: we_o SHALL never be asserted outside WRITE; addr_o and wdata_o hold their last values when we_o=0.

Reset
REQ-032: While rst_i is high, state=IDLE, we_o=0, addr_o=0, wdata_o=0, prog_rst_no=1, done_o=0, err_o=0, and all counters and the byte index are 0.
REQ-033: Reset asserted mid-load SHALL abandon the load immediately; no write occurs on the cycle of or after reset release.

Structure
REQ-034: The FSM state enum, EopWord default and AddrWidth default SHALL live in a shared package prog_loader_pkg.
REQ-035: The block SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-036: Scenario 1: prog_i=1, bytes 78 56 34 12 -> we_o pulse with addr_o=0 and wdata_o=32'h12345678 one cycle after the 4th strobe.
REQ-037: Scenario 2: three words then FF 0F 00 00 -> writes at addresses 0..2, no 4th write, done_o=1, prog_rst_no=1.
REQ-038: Scenario 3: TimeoutCycles=16, two bytes then silence -> err_o=1 at cycle 16 after the last byte, no write; prog_i low -> err_o=0 and prog_rst_no=1.
REQ-039: Scenario 4: AddrWidth=2, five non-EOP words -> four writes (addresses 0..3), then err_o=1 on the 5th word's last byte.
REQ-040: Scenario 5: prog_i dropped after two bytes, then raised and bytes 01 00 00 00 sent -> single write with addr_o=0 and wdata_o=32'h00000001.
REQ-041: Scenario 6: rst_i pulsed mid-word -> all outputs at reset values, and a following full word writes to address 0.
